line_ring_scaler: RTL and testbench

Parametrised single-clock line-ring video scaler. It captures an input raster (PAL/NTSC-class) into a ring of LINES line buffers and replays it on an externally timed output raster (HD-class). Horizontal and vertical resampling use fractional DDA steps, with optional pillarbox bars and a horizontal pan. It sits between the legacy video source and the HDMI transmitter timing generator, and reports underrun and overflow.

---
 rtl/line_ring_scaler.sv | 234 +++++++++++++++++++++++
 tb/tb_line_ring_scaler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_ring_scaler.sv
// line_ring_scaler: single-clock line-ring video scaler.
// The input raster is captured into a ring of LINES line buffers. It is
// replayed on an externally timed output raster with fractional DDA
// resampling in both directions, optional pillarbox bars and a horizontal pan.
module line_ring_scaler #(
  parameter int CH_W     = 8,
  parameter int CHANNELS = 3,
  parameter int LINES    = 8,
  parameter int X_W      = 11,
  parameter int FRAC_W   = 8,
  parameter int VFRAC_W  = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_in_en,
  input  logic                       i_in_de,
  input  logic                       i_in_vsync,
  input  logic [CHANNELS*CH_W-1:0]   i_in_data,
  input  logic                       i_out_en,
  input  logic                       i_out_de,
  input  logic                       i_out_hsync,
  input  logic                       i_out_vsync,
  input  logic [X_W+FRAC_W-1:0]      i_hstep,
  input  logic [VFRAC_W-1:0]         i_vstep,
  input  logic [X_W:0]               i_out_width,
  input  logic [X_W-1:0]             i_bar,
  input  logic [X_W-1:0]             i_hoffset,
  output logic [CHANNELS*CH_W-1:0]   o_data,
  output logic                       o_de,
  output logic                       o_hsync,
  output logic                       o_vsync,
  output logic                       o_frame_end,
  output logic                       o_underrun,
  output logic                       o_overflow
);

  localparam int PIX_W = CHANNELS * CH_W;
  localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int AW    = LW + X_W;
  localparam int HW    = X_W + FRAC_W;
  localparam int XW1   = X_W + 1;
  localparam logic [X_W-1:0] X_LAST     = '1;
  localparam logic [LW-1:0]  AVAIL_FULL = LW'(LINES - 1);

  logic [PIX_W-1:0]   mem [0:(1<<AW)-1];
  logic [PIX_W-1:0]   ram_q;

  logic               in_de_q;
  logic               in_vs_q;
  logic               in_skip;
  logic [LW-1:0]      wr_line;
  logic [X_W-1:0]     wr_x;
  logic [LW-1:0]      avail;
  logic [LW-1:0]      rd_line;
  logic [LW-1:0]      rd_line_nxt;
  logic [VFRAC_W-1:0] vacc;
  logic [VFRAC_W:0]   vsum;
  logic [HW-1:0]      hacc;
  logic [HW-1:0]      cur_hacc;
  logic [XW1-1:0]     out_x;
  logic [XW1-1:0]     cur_x;
  logic [XW1-1:0]     bar_ext;
  logic [XW1-1:0]     right_edge;
  logic [X_W-1:0]     rd_x;
  logic               out_de_q;
  logic               out_vs_q;

  logic               in_pix;
  logic               in_fall;
  logic               in_vs_rise;
  logic               commit;
  logic               out_vs_rise;
  logic               line_start;
  logic               consume_req;
  logic               consume_ok;
  logic               starve;
  logic               full_commit;
  logic               out_pix;
  logic               border;

  logic               en_d1;
  logic               vis_d1;
  logic               de_d1;
  logic               hs_d1;
  logic               vs_d1;

  // After a reset the input side ignores pixels until it has seen blanking,
  // so a line cut by reset is never committed as a partial line.
  assign in_pix      = i_in_en && i_in_de && !in_skip;
  assign in_fall     = i_in_en && !i_in_de && in_de_q;
  assign in_vs_rise  = i_in_vsync && !in_vs_q;
  assign commit      = in_fall && (wr_x != '0) && !in_vs_rise;

  assign out_vs_rise = i_out_vsync && !out_vs_q;
  assign out_pix     = i_out_en && i_out_de;
  assign line_start  = out_pix && !out_de_q;
  assign vsum        = {1'b0, vacc} + {1'b0, i_vstep};
  assign consume_req = line_start && vsum[VFRAC_W];
  assign consume_ok  = consume_req && (avail != '0);
  assign starve      = consume_req && (avail == '0);
  assign full_commit = commit && (avail == AVAIL_FULL) && !consume_ok;

  assign cur_x      = line_start ? '0 : out_x;
  assign cur_hacc   = line_start ? '0 : hacc;
  assign bar_ext    = {1'b0, i_bar};
  assign right_edge = i_out_width - bar_ext;
  assign border     = (cur_x < bar_ext) || (cur_x >= right_edge);
  assign rd_x       = cur_hacc[HW-1:FRAC_W] + i_hoffset;

  // The first pixel of a line already reads the line selected by this cycle's consume.
  always_comb begin
    rd_line_nxt = rd_line;
    if (out_vs_rise)
      rd_line_nxt = '0;
    else if (consume_ok || full_commit)
      rd_line_nxt = rd_line + LW'(1);
  end

  // Input capture: write pointer, line commit and input frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_de_q     <= 1'b0;
      in_vs_q     <= 1'b0;
      in_skip     <= 1'b1;
      wr_line     <= '0;
      wr_x        <= '0;
      o_frame_end <= 1'b0;
    end else begin
      in_vs_q     <= i_in_vsync;
      o_frame_end <= in_vs_rise;
      if (i_in_en) begin
        in_de_q <= i_in_de;
        if (!i_in_de)
          in_skip <= 1'b0;
      end
      if (in_vs_rise) begin
        wr_line <= '0;
        wr_x    <= '0;
      end else if (commit) begin
        wr_line <= wr_line + LW'(1);
        wr_x    <= '0;
      end else if (in_pix && (wr_x != X_LAST)) begin
        wr_x <= wr_x + X_W'(1);
      end
    end
  end

  // Ring occupancy, read line selection, vertical DDA and sticky status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avail      <= '0;
      rd_line    <= '0;
      vacc       <= '0;
      o_overflow <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      rd_line <= rd_line_nxt;
      if (in_vs_rise)
        avail <= '0;
      else if (commit && !consume_ok && !full_commit)
        avail <= avail + LW'(1);
      else if (!commit && consume_ok)
        avail <= avail - LW'(1);

      if (out_vs_rise)
        vacc <= '0;
      else if (line_start)
        vacc <= vsum[VFRAC_W-1:0];

      if (full_commit)
        o_overflow <= 1'b1;
      else if (out_vs_rise)
        o_overflow <= 1'b0;

      if (starve)
        o_underrun <= 1'b1;
      else if (out_vs_rise)
        o_underrun <= 1'b0;
    end
  end

  // Output raster tracking: pixel counter and horizontal DDA accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_de_q <= 1'b0;
      out_vs_q <= 1'b0;
      out_x    <= '0;
      hacc     <= '0;
    end else begin
      out_vs_q <= i_out_vsync;
      if (i_out_en)
        out_de_q <= i_out_de;
      if (out_pix) begin
        out_x <= cur_x + XW1'(1);
        hacc  <= border ? cur_hacc : cur_hacc + i_hstep;
      end
    end
  end

  // Line ring storage with registered read; a same-address write returns old data.
  always_ff @(posedge clk) begin
    if (in_pix)
      mem[{wr_line, wr_x}] <= i_in_data;
    if (out_pix && !border)
      ram_q <= mem[{rd_line_nxt, rd_x}];
  end

  // Two-stage output pipeline keeping data and sync timing aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_d1   <= 1'b0;
      vis_d1  <= 1'b0;
      de_d1   <= 1'b0;
      hs_d1   <= 1'b0;
      vs_d1   <= 1'b0;
      o_data  <= '0;
      o_de    <= 1'b0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
    end else begin
      en_d1   <= i_out_en;
      vis_d1  <= out_pix && !border;
      de_d1   <= i_out_de;
      hs_d1   <= i_out_hsync;
      vs_d1   <= i_out_vsync;
      o_de    <= de_d1;
      o_hsync <= hs_d1;
      o_vsync <= vs_d1;
      if (en_d1)
        o_data <= vis_d1 ? ram_q : '0;
    end
  end

endmodule

// File: tb/tb_line_ring_scaler.sv
// tb_line_ring_scaler: scoreboard bench for the line ring scaler.
// A behavioural ring model predicts every output pixel; a table of line
// configurations adds hand-derived spot values, and directed sequences
// cover vertical scaling, underrun, overflow and asynchronous reset.
module tb_line_ring_scaler;

  localparam int CH_W     = 8;
  localparam int CHANNELS = 3;
  localparam int LINES    = 8;
  localparam int X_W      = 11;
  localparam int FRAC_W   = 8;
  localparam int VFRAC_W  = 12;
  localparam int PIX_W    = CHANNELS * CH_W;
  localparam int HW       = X_W + FRAC_W;
  localparam int XW1      = X_W + 1;

  logic              clk;
  logic              reset_n;
  logic              i_in_en, i_in_de, i_in_vsync;
  logic [PIX_W-1:0]  i_in_data;
  logic              i_out_en, i_out_de, i_out_hsync, i_out_vsync;
  logic [HW-1:0]     i_hstep;
  logic [VFRAC_W-1:0] i_vstep;
  logic [XW1-1:0]    i_out_width;
  logic [X_W-1:0]    i_bar;
  logic [X_W-1:0]    i_hoffset;
  logic [PIX_W-1:0]  o_data;
  logic              o_de, o_hsync, o_vsync, o_frame_end, o_underrun, o_overflow;

  line_ring_scaler #(
    .CH_W(CH_W), .CHANNELS(CHANNELS), .LINES(LINES),
    .X_W(X_W), .FRAC_W(FRAC_W), .VFRAC_W(VFRAC_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_in_en(i_in_en), .i_in_de(i_in_de), .i_in_vsync(i_in_vsync), .i_in_data(i_in_data),
    .i_out_en(i_out_en), .i_out_de(i_out_de), .i_out_hsync(i_out_hsync), .i_out_vsync(i_out_vsync),
    .i_hstep(i_hstep), .i_vstep(i_vstep), .i_out_width(i_out_width),
    .i_bar(i_bar), .i_hoffset(i_hoffset),
    .o_data(o_data), .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_frame_end(o_frame_end), .o_underrun(o_underrun), .o_overflow(o_overflow)
  );

  typedef struct {
    int hstep;
    int width;
    int bar;
    int hoff;
    int probe_x;
    int probe_idx;
  } vec_t;

  logic [PIX_W-1:0] ref_mem [0:LINES-1][0:2047];
  logic [PIX_W-1:0] cap [0:2047];
  logic [PIX_W-1:0] exp_q [$];
  int  m_wr_line, m_wr_x, m_avail, m_rd, m_vacc;
  bit  m_under, m_over;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_on;
  bit  de_prev;
  int  mon_x;

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PIX_W-1:0] mk_pix(int tag, int x);
    return {8'(tag), 8'(x >> 8), 8'(x)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Captures each output line and checks every active pixel against the scoreboard.
  always @(negedge clk) begin
    if (o_de) begin
      if (!de_prev)
        mon_x = 0;
      if (mon_x < 2048)
        cap[mon_x] = o_data;
      mon_x++;
      if (mon_on) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL pix_extra: got %0h, wanted no pixel", o_data);
        end else begin
          checkOutput("pix", 32'(o_data), 32'(exp_q.pop_front()));
        end
      end
    end
    de_prev = o_de;
  end

  task automatic send_line(int tag, int n);
    step(); i_in_en = 1'b1; i_in_de = 1'b0;
    for (int x = 0; x < n; x++) begin
      step();
      i_in_de   = 1'b1;
      i_in_data = mk_pix(tag, x);
      ref_mem[m_wr_line][m_wr_x] = mk_pix(tag, x);
      if (m_wr_x < 2047) m_wr_x++;
    end
    step(); i_in_de = 1'b0;
    if (m_wr_x != 0) begin
      m_wr_line = (m_wr_line + 1) % LINES;
      m_wr_x    = 0;
      if (m_avail == LINES - 1) begin
        m_rd   = (m_rd + 1) % LINES;
        m_over = 1'b1;
      end else begin
        m_avail++;
      end
    end
    step(); i_in_en = 1'b0;
  endtask

  task automatic out_line(int width, int bar, int hstep, int hoff, int vstep);
    int hacc;
    int idx;
    logic [PIX_W-1:0] e;
    i_hstep = HW'(hstep); i_out_width = XW1'(width); i_bar = X_W'(bar);
    i_hoffset = X_W'(hoff); i_vstep = VFRAC_W'(vstep);
    m_vacc += vstep;
    if (m_vacc >= 4096) begin
      m_vacc -= 4096;
      if (m_avail > 0) begin
        m_rd = (m_rd + 1) % LINES;
        m_avail--;
      end else begin
        m_under = 1'b1;
      end
    end
    hacc = 0;
    for (int x = 0; x < width; x++) begin
      if (x < bar || x >= width - bar) begin
        e = '0;
      end else begin
        idx  = ((hacc >> 8) + hoff) % 2048;
        e    = ref_mem[m_rd][idx];
        hacc = (hacc + hstep) % (1 << HW);
      end
      exp_q.push_back(e);
      step(); i_out_en = 1'b1; i_out_de = 1'b1;
    end
    step(); i_out_de = 1'b0;
    repeat (4) step();
  endtask

  task automatic in_vsync_pulse(bit chk);
    step(); i_in_vsync = 1'b1;
    step();
    if (chk) checkOutput("frame_end_pulse", 32'(o_frame_end), 32'd1);
    i_in_vsync = 1'b0;
    step();
    if (chk) checkOutput("frame_end_clear", 32'(o_frame_end), 32'd0);
    m_wr_line = 0; m_wr_x = 0; m_avail = 0;
  endtask

  task automatic out_vsync_pulse(bit chk);
    step(); i_out_vsync = 1'b1;
    step();
    if (chk) checkOutput("o_vsync_early", 32'(o_vsync), 32'd0);
    step();
    if (chk) checkOutput("o_vsync_delay2", 32'(o_vsync), 32'd1);
    i_out_vsync = 1'b0;
    step();
    m_rd = 0; m_vacc = 0; m_under = 1'b0; m_over = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    logic [PIX_W-1:0] e;
    out_line(v.width, v.bar, v.hstep, v.hoff, 0);
    e = (v.probe_idx < 0) ? '0 : mk_pix(0, v.probe_idx);
    checkOutput($sformatf("vec%0d_probe", n), 32'(cap[v.probe_x]), 32'(e));
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_data"},  32'(o_data),      32'd0);
    checkOutput({tag, "_de"},    32'(o_de),        32'd0);
    checkOutput({tag, "_hs"},    32'(o_hsync),     32'd0);
    checkOutput({tag, "_vs"},    32'(o_vsync),     32'd0);
    checkOutput({tag, "_fe"},    32'(o_frame_end), 32'd0);
    checkOutput({tag, "_under"}, 32'(o_underrun),  32'd0);
    checkOutput({tag, "_over"},  32'(o_overflow),  32'd0);
  endtask

  // Guards against a hung run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    vec_t vecs [5];
    vecs[0] = '{hstep: 'h100, width: 720,  bar: 0,   hoff: 0,  probe_x: 719,  probe_idx: 719};
    vecs[1] = '{hstep: 'h080, width: 720,  bar: 0,   hoff: 0,  probe_x: 5,    probe_idx: 2};
    vecs[2] = '{hstep: 'h0A0, width: 1280, bar: 160, hoff: 37, probe_x: 160,  probe_idx: 37};
    vecs[3] = '{hstep: 'h0A0, width: 1280, bar: 160, hoff: 37, probe_x: 162,  probe_idx: 38};
    vecs[4] = '{hstep: 'h0A0, width: 1280, bar: 160, hoff: 37, probe_x: 1120, probe_idx: -1};

    reset_n = 1'b0;
    i_in_en = 1'b0; i_in_de = 1'b0; i_in_vsync = 1'b0; i_in_data = '0;
    i_out_en = 1'b0; i_out_de = 1'b0; i_out_hsync = 1'b0; i_out_vsync = 1'b0;
    i_hstep = HW'('h100); i_vstep = '0; i_out_width = XW1'(720); i_bar = '0; i_hoffset = '0;
    m_wr_line = 0; m_wr_x = 0; m_avail = 0; m_rd = 0; m_vacc = 0;
    m_under = 1'b0; m_over = 1'b0;
    mon_on = 1'b1; de_prev = 1'b0; mon_x = 0;

    repeat (3) step();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    step();

    // Unity, 2x horizontal and pillarbox from one 720-pixel ramp line.
    out_vsync_pulse(1'b1);
    in_vsync_pulse(1'b1);
    send_line(0, 720);
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Vertical 0.5: each committed line is shown twice.
    out_vsync_pulse(1'b0);
    in_vsync_pulse(1'b0);
    send_line(1, 16); send_line(2, 16); send_line(3, 16);
    for (int l = 0; l < 5; l++) out_line(16, 0, 'h100, 0, 'h800);
    checkOutput("vert_no_underrun", 32'(o_underrun), 32'(m_under));

    // Underrun: consumption outruns commits, the last line repeats.
    out_vsync_pulse(1'b0);
    in_vsync_pulse(1'b0);
    send_line(4, 16);
    for (int l = 0; l < 4; l++) out_line(16, 0, 'h100, 0, 'h800);
    checkOutput("underrun_set", 32'(o_underrun), 32'(m_under));
    checkOutput("underrun_set_const", 32'(o_underrun), 32'd1);
    out_vsync_pulse(1'b0);
    checkOutput("underrun_cleared", 32'(o_underrun), 32'd0);

    // Overflow: eight commits with no consume drop the oldest line.
    in_vsync_pulse(1'b0);
    for (int k = 0; k < 8; k++) send_line(10 + k, 8);
    checkOutput("overflow_set", 32'(o_overflow), 32'd1);
    out_line(8, 0, 'h100, 0, 0);
    checkOutput("overflow_rd_adv", 32'(cap[3]), 32'(mk_pix(11, 3)));
    out_vsync_pulse(1'b0);
    checkOutput("overflow_cleared", 32'(o_overflow), 32'd0);

    // Asynchronous reset in the middle of an input and an output line.
    mon_on = 1'b0;
    i_out_width = XW1'(16); i_bar = '0; i_hoffset = '0; i_vstep = '0;
    step(); i_in_en = 1'b1; i_in_de = 1'b1; i_out_en = 1'b1; i_out_de = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_in_data = mk_pix(77, k);
      step();
    end
    checkOutput("pre_reset_de", 32'(o_de), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    i_out_de = 1'b0;
    step(); step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      i_in_data = mk_pix(99, k);
    end
    exp_q.delete();
    m_wr_line = 0; m_wr_x = 0; m_avail = 0; m_rd = 0; m_vacc = 0;
    m_under = 1'b0; m_over = 1'b0;
    mon_on = 1'b1;
    send_line(9, 16);
    out_line(16, 0, 'h100, 0, 0);
    checkOutput("post_reset_slot0", 32'(cap[7]), 32'(mk_pix(9, 7)));

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step();
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
